// File: rtl/debug_uart_tx.sv
// debug_uart_tx: FIFO-buffered debug UART transmitter with a CPU-style status port.
// Frame: start, 8 data bits LSB first, optional even parity, one stop bit.
// Optional feature macro: DEBUG_UART_PARITY_EN adds the even-parity bit.
module debug_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        csb_i,
    input  logic        wen_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        tx_o,
    output logic        overflow_o
);
    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(FIFO_DEPTH);

`ifdef DEBUG_UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic              push_req;
    logic              push_ok;
    logic              pop;
    logic              full;
    logic              empty;
    logic              bit_end;
    logic              busy;
    logic              active_q;
    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    state_t            state;
    logic [BAUD_W-1:0] baud;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;
`ifdef DEBUG_UART_PARITY_EN
    logic              parity_q;
`endif
    logic              unused_data;

    assign push_req    = ~csb_i & ~wen_i;
    assign full        = (count == FIFO_FULL);
    assign empty       = (count == '0);
    assign bit_end     = (baud == BAUD_LAST);
    assign pop         = ~empty & ((state == IDLE) | ((state == STOP) & bit_end));
    assign push_ok     = push_req & (~full | pop);
    // active_q keeps busy high while the final stop bit is still on the line
    assign busy        = (state != IDLE) | ~empty | active_q;
    assign data_o      = {16'h0, 8'(count), 5'h0, overflow_o, full, busy};
    assign unused_data = ^data_i[31:8];

    // FIFO storage; contents need no reset since pointers define validity
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr] <= data_i[7:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_req && !push_ok) begin
                overflow_o <= 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Frame FSM with baud counter; tx_o is registered from the current state
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state    <= IDLE;
            baud     <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx_o     <= 1'b1;
            active_q <= 1'b0;
`ifdef DEBUG_UART_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            active_q <= (state != IDLE);
            baud     <= bit_end ? '0 : baud + BAUD_W'(1);
            case (state)
                IDLE: begin
                    tx_o <= 1'b1;
                    baud <= '0;
                    if (pop) begin
                        state <= START;
                        shift <= mem[rd_ptr];
`ifdef DEBUG_UART_PARITY_EN
                        parity_q <= ^mem[rd_ptr];
`endif
                    end
                end
                START: begin
                    tx_o <= 1'b0;
                    if (bit_end) begin
                        state   <= DATA;
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    tx_o <= shift[0];
                    if (bit_end) begin
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef DEBUG_UART_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef DEBUG_UART_PARITY_EN
                PARITY: begin
                    tx_o <= parity_q;
                    if (bit_end) begin
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    tx_o <= 1'b1;
                    if (bit_end) begin
                        if (pop) begin
                            state <= START;
                            shift <= mem[rd_ptr];
`ifdef DEBUG_UART_PARITY_EN
                            parity_q <= ^mem[rd_ptr];
`endif
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    tx_o  <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_uart_tx.sv
// tb_debug_uart_tx: directed bench for debug_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
module tb_debug_uart_tx;
    localparam int CPB = 4;
`ifdef DEBUG_UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = CPB * NB;

    typedef struct {
        logic [7:0]  data;
        logic        par;
        logic [31:0] status;
    } vec_t;

    logic        clk_i;
    logic        reset_i;
    logic        csb_i;
    logic        wen_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        tx_o;
    logic        overflow_o;

    int          cyc;
    int          n_total;
    int          n_pass;
    int          k;
    vec_t        tbl [7];
    logic [7:0]  exp_q [$];
    logic        par_q [$];
    logic [7:0]  tmp;

    debug_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .csb_i     (csb_i),
        .wen_i     (wen_i),
        .data_i    (data_i),
        .data_o    (data_o),
        .tx_o      (tx_o),
        .overflow_o(overflow_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_i);
        cyc++;
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic do_reset();
        csb_i   = 1'b1;
        wen_i   = 1'b1;
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] b);
        csb_i  = 1'b0;
        wen_i  = 1'b0;
        data_i = {24'($urandom), b};
        tick();
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input logic par, input int p);
        if (p == 0) return 1'b0;
        if (p <= 8) return b[p-1];
        if (NB == 11 && p == 9) return par;
        return 1'b1;
    endfunction

    // Compare tx_o and busy against the frame model for queued bytes, from the
    // current cycle up to (not including) offset stop_off after write edge k.
    task automatic check_stream(input int kk, input int n, input bit reads, input int stop_off);
        int   off;
        int   f;
        int   last;
        logic et;
        logic eb;
        last = 2 + n * FRAME;
        while (cyc - kk < stop_off) begin
            off = cyc - kk;
            if (off < 2) begin
                et = 1'b1;
            end else begin
                f = (off - 2) / FRAME;
                if (f >= n) et = 1'b1;
                else et = exp_bit(exp_q[f], par_q[f], ((off - 2) % FRAME) / CPB);
            end
            eb = (off < last);
            check("tx", 32'(tx_o), 32'(et));
            check("busy", 32'(data_o[0]), 32'(eb));
            if (reads && off[0]) begin
                csb_i  = 1'b0;
                wen_i  = 1'b1;
                data_i = $urandom;
            end else begin
                csb_i = 1'b1;
                wen_i = 1'b1;
            end
            tick();
        end
        csb_i = 1'b1;
        wen_i = 1'b1;
    endtask

    initial begin
        cyc     = 0;
        n_total = 0;
        n_pass  = 0;
        csb_i   = 1'b1;
        wen_i   = 1'b1;
        data_i  = '0;
        reset_i = 1'b1;

        tbl[0] = '{8'h55, 1'b0, 32'h0000_0101};
        tbl[1] = '{8'h07, 1'b1, 32'h0000_0101};
        tbl[2] = '{8'h03, 1'b0, 32'h0000_0101};
        tbl[3] = '{8'h00, 1'b0, 32'h0000_0101};
        tbl[4] = '{8'hFF, 1'b0, 32'h0000_0101};
        tbl[5] = '{8'h80, 1'b1, 32'h0000_0101};
        tbl[6] = '{8'hA4, 1'b1, 32'h0000_0101};

        // reset state
        do_reset();
        check("rst_data_o", data_o, 32'h0);
        check("rst_tx", 32'(tx_o), 32'h1);
        check("rst_overflow", 32'(overflow_o), 32'h0);

        // single frames: exact latency, bit timing, parity and busy release
        for (int i = 0; i < 7; i++) begin
            do_reset();
            exp_q.delete();
            par_q.delete();
            exp_q.push_back(tbl[i].data);
            par_q.push_back(tbl[i].par);
            do_write(tbl[i].data);
            k     = cyc;
            csb_i = 1'b1;
            wen_i = 1'b1;
            check("vec_status", data_o, tbl[i].status);
            check_stream(k, 1, (i % 2) == 1, 2 + FRAME + 2);
            check("vec_idle", data_o, 32'h0);
        end

        // overflow: six consecutive writes into a depth-4 FIFO, reads interleaved
        do_reset();
        exp_q.delete();
        par_q.delete();
        for (int b = 1; b <= 6; b++) begin
            do_write(8'(b));
            if (b == 1) k = cyc;
        end
        csb_i = 1'b1;
        wen_i = 1'b1;
        check("ovf_status", data_o, 32'h0000_0407);
        check("ovf_flag", 32'(overflow_o), 32'h1);
        for (int b = 1; b <= 5; b++) begin
            tmp = 8'(b);
            exp_q.push_back(tmp);
            par_q.push_back(^tmp);
        end
        check_stream(k, 5, 1'b1, 2 + 5 * FRAME + 2);
        check("ovf_sticky", data_o, 32'h0000_0004);

        // write on the edge leaving STOP with a full FIFO
        do_reset();
        exp_q.delete();
        par_q.delete();
        for (int b = 0; b < 5; b++) begin
            tmp = 8'h10 + 8'(b);
            do_write(tmp);
            if (b == 0) k = cyc;
            exp_q.push_back(tmp);
            par_q.push_back(^tmp);
        end
        tmp = 8'hC3;
        exp_q.push_back(tmp);
        par_q.push_back(^tmp);
        check_stream(k, 6, 1'b0, FRAME);
        check("full_before_stop", data_o, 32'h0000_0403);
        do_write(8'hC3);
        csb_i = 1'b1;
        wen_i = 1'b1;
        check("full_push_pop", data_o, 32'h0000_0403);
        check("full_no_overflow", 32'(overflow_o), 32'h0);
        check_stream(k, 6, 1'b0, 2 + 6 * FRAME + 2);
        check("full_idle", data_o, 32'h0);

        // reset during data bit 3 with two bytes queued
        do_reset();
        exp_q.delete();
        par_q.delete();
        for (int b = 0; b < 3; b++) begin
            tmp = 8'h11 * 8'(b);
            do_write(tmp);
            if (b == 0) k = cyc;
            exp_q.push_back(tmp);
            par_q.push_back(^tmp);
        end
        check_stream(k, 3, 1'b0, 18);
        check("pre_reset_tx", 32'(tx_o), 32'h0);
        reset_i = 1'b1;
        #1;
        check("abort_tx", 32'(tx_o), 32'h1);
        check("abort_data_o", data_o, 32'h0);
        tick();
        tick();
        reset_i = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            check("post_abort_tx", 32'(tx_o), 32'h1);
            check("post_abort_data_o", data_o, 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/debug_uart_tx.md
DEBUG_UART_TX -- requirements
Module: debug_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per UART bit period; legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 8, depth of the byte buffer; power of two, 2..64.
REQ-003 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_i  input  1  asynchronous, active-high reset.
REQ-005 csb_i  input  1  active-low chip select, registered upstream, one cycle per access.
REQ-006 wen_i  input  1  active-low write enable, qualified by csb_i.
REQ-007 data_i  input  32  write data; only [7:0] is used.
REQ-008 data_o  output  32  status word: [0] busy, [1] fifo_full, [2] overflow, [15:8] fifo_count, others 0.
REQ-009 tx_o  output  1  UART serial line, idle high.
REQ-010 overflow_o  output  1  sticky flag, set when a write is dropped.

Function
REQ-011 A write (csb_i=0, wen_i=0 at a rising edge) shall push data_i[7:0] into the FIFO when the FIFO is not full.
REQ-012 A write while the FIFO is full and no pop occurs in the same cycle shall drop the byte, leave the FIFO unchanged and set overflow_o.
REQ-013 A simultaneous push and pop on a full FIFO shall accept the push; fifo_count stays at FIFO_DEPTH.
REQ-014 Read access (csb_i=0, wen_i=1) shall have no side effects; data_o shall be valid combinationally from current state at all times.
REQ-015 FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
REQ-016 IDLE -> START when the FIFO is non-empty; the head byte is popped into a shift register on that same edge.
REQ-017 The baud counter shall restart at 0 on every state entry; each of START, DATA-bit, PARITY and STOP shall last exactly CLKS_PER_BIT cycles.
REQ-018 tx_o shall be: IDLE 1, START 0, DATA shift[0] (LSB first, 8 bits), PARITY as per Configuration, STOP 1.
REQ-019 After STOP: if the FIFO is non-empty, go straight to START and pop (back-to-back frames, no idle gap); otherwise go to IDLE.
REQ-020 Latency: a write sampled at edge k into an empty FIFO with FSM in IDLE shall drive tx_o low from edge k+2.
REQ-021 busy shall be 1 whenever the FSM is not IDLE or the FIFO is non-empty.
REQ-022 FIFO read and write pointers shall wrap modulo FIFO_DEPTH; fifo_count uses log2(FIFO_DEPTH)+1 bits, zero-extended into [15:8].

Reset
REQ-023 When reset_i is asserted, the block shall asynchronously set tx_o=1, overflow_o=0, FSM=IDLE, FIFO empty (count 0, pointers 0), baud counter 0, shift register 0.
REQ-024 Asserting reset in mid-frame shall abort the frame immediately with tx_o=1; FIFO contents are discarded.
REQ-025 The first write after reset deasserts shall be accepted in the first clock edge at which reset_i is low.

Configuration
REQ-026 Macro DEBUG_UART_PARITY_EN: when defined, each frame shall contain a PARITY state after DATA driving even parity (XOR of the 8 data bits), giving 11 bit periods per frame.
REQ-027 When DEBUG_UART_PARITY_EN is undefined, the PARITY state and its logic shall be absent and a frame shall be 10 bit periods (DATA -> STOP).

Verification
REQ-028 CLKS_PER_BIT=4, no parity, write 0x55 at edge k -> tx_o low at edges k+2..k+5, then 1,0,1,0,1,0,1,0 for 4 cycles each, then high for 4 cycles; busy=0 from edge k+42.
REQ-029 DEBUG_UART_PARITY_EN, CLKS_PER_BIT=4, write 0x07 -> parity bit 1; write 0x03 -> parity bit 0; each frame 44 cycles.
REQ-030 FIFO_DEPTH=4, 6 writes 0x01..0x06 in consecutive cycles while idle -> 0x01 popped, 0x02..0x05 buffered, 0x06 dropped, overflow_o=1, data_o[15:8]=4; serial output 0x01..0x05 back-to-back with no idle gap.
REQ-031 Write on the same edge that the FSM leaves STOP with a full FIFO -> push accepted, count stays FIFO_DEPTH, overflow_o unchanged.
REQ-032 Assert reset_i during DATA bit 3 of a frame with 2 bytes queued -> tx_o=1 within the same cycle, data_o=0, no further frames after release.
REQ-033 Read (csb_i=0, wen_i=1) during a frame -> data_o[0]=1 and FIFO and FSM unchanged.
